counter_timer_arbiter: RTL and testbench
========================================

// Module: counter_timer_arbiter
// PURPOSE
//   Shares one CW-bit up-counter (timer) among NREQ requesters using round-robin arbitration.
//   A granted requester receives a run of (len+1) counted cycles, then a one-cycle done pulse.
//   Sits between client FSMs needing short delays and the single counter resource.
//   Provides sequencing (start/stop/terminal detect) for the shared counter.
// PARAMETERS
//   NREQ  4  number of requesters (>=2)
//   CW    3  counter / length width in bits
// PORTS
//   clk      in   1        clock, all state updates on posedge
//   rstn     in   1        async active-low reset
//   req      in   NREQ     per-requester request level; hold high until done
//   req_len  in   NREQ*CW  per-requester terminal count; slot i = [i*CW +: CW]
//   gnt      out  NREQ     one-hot, high while requester owns the counter
//   done     out  NREQ     one-hot one-cycle pulse at end of a completed run
//   busy     out  1        high in RUN and DONE states
//   cntout   out  CW       current counter value
// BEHAVIOUR
//   Reset (rstn=0, async):
//   - state=IDLE; gnt=0, done=0, busy=0, cntout=0.
//   - RR pointer=0; latched len/owner=0.
//   - All outputs are registered; no combinational path from req to the outputs.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: if any req bit is high, pick the first set bit at or after ptr, searching upward with wrap.
//     Next edge: owner<=i, len<=req_len[i], gnt<=onehot(i), cntout<=0, busy<=1, state<=RUN.
//     No req: stay in IDLE, outputs held at their reset values.
//   - RUN, priority order per edge:
//     (1) req[owner]==0: abort. gnt<=0, cntout<=0, busy<=0, state<=IDLE, no done pulse, ptr<=owner+1.
//     (2) cntout==len: gnt<=0, done<=onehot(owner), state<=DONE.
//     (3) otherwise cntout<=cntout+1.
//   - DONE: done<=0, busy<=0, cntout<=0, ptr<=owner+1 (mod NREQ), state<=IDLE.
//   Timing:
//   - gnt is high for exactly len+1 cycles, and cntout shows 0..len during them.
//   - done rises on the edge that drops gnt.
//   - Minimum req-sampled-to-gnt latency is 1 cycle.
//   - Back-to-back grants are separated by 2 cycles (DONE, then IDLE).
//   Width/boundaries:
//   - len=0 gives a single gnt cycle.
//   - len=2^CW-1 counts to all-ones; cntout never wraps because the run terminates at len.
//   - req_len is sampled only at grant; later changes are ignored until the next grant.
//   - Requests from non-owners during RUN/DONE are ignored (not queued); they are re-evaluated in IDLE.
//   - If the owner keeps req high after done, it is a new request but has lowest RR priority.
//   - Reset asserted mid-RUN: immediate return to reset values; no done pulse.
// TESTING
//   T1 single:
//   - req=0001, len0=3 -> gnt=0001 for 4 cycles, cntout 0,1,2,3.
//   - Then done=0001 for 1 cycle, busy falls 1 cycle later.
//   T2 fairness:
//   - req=1111 held continuously, all len=1 -> grant order 0,1,2,3,0.
//   - Each gnt lasts 2 cycles; 2-cycle gap between grants.
//   T3 boundaries:
//   - len=0 -> gnt 1 cycle, cntout=0, then done.
//   - len=7 (CW=3) -> cntout 0..7, no wrap, done after 8 gnt cycles.
//   T4 abort:
//   - req1 granted with len=5; drop req1 when cntout=2.
//   - Next edge: gnt=0, cntout=0, busy=0, done never pulses.
//   - Next grant goes to req2 if pending.
//   T5 reset mid-run:
//   - Assert rstn=0 while cntout=4 -> all outputs 0 immediately.
//   - After release, ptr=0 and req=1010 grants requester 1 first.
//   T6 late change:
//   - Change req_len[owner] from 6 to 2 during RUN -> run still ends at cntout=6.

Source files
------------

// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter sharing one CW-bit up-counter among NREQ requesters.
// A granted requester gets (len+1) counted cycles followed by a one-cycle done pulse.
module counter_timer_arbiter #(
   parameter int NREQ = 4,
   parameter int CW   = 3
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] req_len,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic               busy,
   output logic [CW-1:0]      cntout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [CW-1:0]     len_q, len_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic              busy_q, busy_d;

   logic              found;
   logic [PW-1:0]     pick;
   logic [PW-1:0]     cand;
   logic [PW:0]       sum;
   logic [PW-1:0]     owner_next;

   // First requester at or after ptr, searching upward with wrap.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sum   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         cand = sum[PW-1:0];
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign owner_next = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      done_d  = done_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            gnt_d  = '0;
            done_d = '0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (found) begin
               owner_d = pick;
               len_d   = req_len[int'(pick)*CW +: CW];
               gnt_d   = ONE << pick;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Abort outranks terminal count: a dropped request never yields done.
            if (!req[owner_q]) begin
               gnt_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = owner_next;
               state_d = S_IDLE;
            end else if (cnt_q == len_q) begin
               gnt_d   = '0;
               done_d  = ONE << owner_q;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done_d  = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            ptr_d   = owner_next;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign cntout = cnt_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Scoreboard bench for counter_timer_arbiter: batches of requests are turned into
// expected grant records (owner, run length, completion, gap) and checked by a monitor.
module tb_counter_timer_arbiter;

   localparam int N  = 4;
   localparam int CW = 3;

   logic            clk;
   logic            rstn;
   logic [N-1:0]    req;
   logic [N*CW-1:0] req_len;
   logic [N-1:0]    gnt;
   logic [N-1:0]    done;
   logic            busy;
   logic [CW-1:0]   cntout;

   counter_timer_arbiter #(.NREQ(N), .CW(CW)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req),
      .req_len (req_len),
      .gnt     (gnt),
      .done    (done),
      .busy    (busy),
      .cntout  (cntout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int cycles;
      bit completed;
      int gap;
   } rec_t;

   rec_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_ptr    = 0;
   int   b_len[N];
   int   b_ab[N];

   task automatic chk(input string name, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req_v, $time);
      end
   endtask

   // Monitor: pops one expected record per observed grant run.
   initial begin : monitor
      rec_t         e;
      bit           in_run;
      int           cyc;
      int           low_cnt;
      logic [N-1:0] cur;
      in_run  = 1'b0;
      cyc     = 0;
      low_cnt = 2;
      cur     = '0;
      e       = '{-1, 0, 1'b0, -1};
      forever begin
         @(negedge clk);
         if (!rstn) begin
            in_run  = 1'b0;
            low_cnt = 2;
         end else if (gnt != '0) begin
            if (!in_run) begin
               in_run = 1'b1;
               cyc    = 0;
               cur    = gnt;
               chk("grant_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) e = exp_q.pop_front();
               else e = '{-1, 0, 1'b0, -1};
               chk("gnt_owner", int'(gnt), (e.idx >= 0) ? (1 << e.idx) : 0);
               if (e.gap >= 0) chk("grant_gap", low_cnt, e.gap);
            end
            chk("gnt_stable", int'(gnt), int'(cur));
            chk("cntout_seq", int'(cntout), cyc);
            chk("busy_in_run", int'(busy), 1);
            chk("no_done_in_run", int'(done), 0);
            cyc++;
         end else if (in_run) begin
            in_run  = 1'b0;
            low_cnt = 1;
            chk("run_length", cyc, e.cycles);
            chk("done_pulse", int'(done), (e.completed && e.idx >= 0) ? (1 << e.idx) : 0);
            chk("busy_after_run", int'(busy), e.completed ? 1 : 0);
         end else begin
            low_cnt++;
            chk("idle_done", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_cntout", int'(cntout), 0);
         end
      end
   end

   // One negedge of client behaviour: drop req on done or at the chosen abort count,
   // and scramble the owner's req_len slot to show it is ignored after grant.
   task automatic client_step();
      for (int i = 0; i < N; i++) begin
         if (done[i]) req[i] = 1'b0;
         if (gnt[i]) begin
            if (b_ab[i] >= 0 && int'(cntout) == b_ab[i]) req[i] = 1'b0;
            req_len[i*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
         end
      end
   endtask

   // Model: all masked requesters held until served, so grants follow RR order from m_ptr.
   task automatic run_batch(input logic [N-1:0] mask);
      rec_t r;
      bit   first;
      bit   prev_done;
      bit   fin;
      int   last;
      first     = 1'b1;
      prev_done = 1'b0;
      fin       = 1'b0;
      last      = -1;
      for (int i = 0; i < N; i++) begin
         if (mask[i]) req_len[i*CW +: CW] = CW'(b_len[i]);
      end
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (mask[i]) begin
            r.idx       = i;
            r.completed = (b_ab[i] < 0);
            r.cycles    = r.completed ? b_len[i] + 1 : b_ab[i] + 1;
            r.gap       = first ? -1 : (prev_done ? 2 : 1);
            first       = 1'b0;
            prev_done   = r.completed;
            exp_q.push_back(r);
            last = i;
         end
      end
      if (last >= 0) m_ptr = (last + 1) % N;
      req = mask;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         client_step();
         if (req == '0 && !busy && gnt == '0) fin = 1'b1;
      end
      chk("batch_finished", int'(fin), 1);
   endtask

   task automatic set_all(input int len, input int ab);
      for (int i = 0; i < N; i++) begin
         b_len[i] = len;
         b_ab[i]  = ab;
      end
   endtask

   initial begin : stimulus
      rstn    = 1'b0;
      req     = '0;
      req_len = '0;
      set_all(0, -1);
      repeat (3) @(negedge clk);
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_cntout", int'(cntout), 0);
      rstn = 1'b1;
      @(negedge clk);

      // single request, len 3
      set_all(0, -1); b_len[0] = 3;
      run_batch(4'b0001);
      // fairness: everyone requests, then requester 0 again
      set_all(1, -1);
      run_batch(4'b1111);
      run_batch(4'b0001);
      // boundaries: len 0 and len all-ones
      set_all(0, -1); b_len[1] = 0;
      run_batch(4'b0010);
      set_all(0, -1); b_len[0] = (1 << CW) - 1;
      run_batch(4'b0001);
      // abort: requester 1 drops at count 2, requester 2 is served next
      set_all(0, -1); b_len[1] = 5; b_ab[1] = 2; b_len[2] = 3;
      run_batch(4'b0110);
      // late req_len change on the owner is ignored
      set_all(0, -1); b_len[0] = 6;
      run_batch(4'b0001);

      // reset in the middle of a run
      set_all(0, -1); b_len[0] = 6;
      begin
         rec_t r;
         bit   hit;
         r = '{0, 7, 1'b1, -1};
         exp_q.push_back(r);
         req_len[0 +: CW] = CW'(6);
         req = 4'b0001;
         hit = 1'b0;
         for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (cntout == CW'(4)) hit = 1'b1;
         end
         chk("reached_cnt4", int'(cntout), 4);
         #2 rstn = 1'b0;
         #1;
         chk("midrun_rst_gnt", int'(gnt), 0);
         chk("midrun_rst_done", int'(done), 0);
         chk("midrun_rst_busy", int'(busy), 0);
         chk("midrun_rst_cntout", int'(cntout), 0);
         @(negedge clk);
         req = '0;
         exp_q.delete();
         m_ptr = 0;
         @(negedge clk);
         rstn = 1'b1;
      end
      set_all(2, -1);
      run_batch(4'b1010);

      // randomized batches
      for (int it = 0; it < 40; it++) begin
         logic [N-1:0] mask;
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            b_len[i] = int'($urandom_range(0, (1 << CW) - 1));
            if ($urandom_range(0, 3) == 0) b_ab[i] = int'($urandom_range(0, b_len[i]));
            else b_ab[i] = -1;
         end
         run_batch(mask);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
